// File: rtl/if_stage.sv
// Instruction fetch stage. It issues one instruction-memory read at a time,
// holds the IF/ID pipeline register, and keeps a one-entry skid buffer so
// that a word returned while decode is stalled is never dropped. Redirects
// restart the fetch stream. A redirect that arrives while a request is still
// waiting is handled by letting that stale request finish and throwing its
// data away.
module if_stage #(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        stall_i,
    input  logic        redirect_i,
    input  logic [31:0] redirect_pc_i,
    output logic        imem_req_o,
    output logic [31:0] imem_addr_o,
    input  logic        imem_ack_i,
    input  logic [31:0] imem_rdata_i,
    output logic [31:0] pc_o,
    output logic [31:0] inst_o,
    output logic        valid_o
);

    typedef enum logic [1:0] {
        FETCH = 2'd0,   // request outstanding at fetch_pc
        SKID  = 2'd1,   // one word parked in the skid buffer, no request
        FLUSH = 2'd2    // stale request outstanding, its data is dropped
    } state_t;

    state_t      state, state_n;
    logic [31:0] fetch_pc, fetch_pc_n;    // address of the current request
    logic [31:0] flush_pc, flush_pc_n;    // where to resume once FLUSH ends
    logic [31:0] skid_pc, skid_pc_n;
    logic [31:0] skid_inst, skid_inst_n;
    logic [31:0] pc_n, inst_n;
    logic        valid_n;
    logic        ack;
    logic [31:0] target;

    // The request is held low for as long as reset is asserted, so the first
    // request at RESET_PC is raised in the cycle right after reset falls.
    assign imem_req_o  = !rst && (state != SKID);
    assign imem_addr_o = fetch_pc;
    // An acknowledge with no request pending is meaningless and is ignored.
    assign ack         = imem_req_o && imem_ack_i;
    assign target      = {redirect_pc_i[31:2], 2'b00};

    // Next-state and next-register values; a redirect overrides everything.
    always_comb begin
        // NOTE: every signal written here is given its hold value first, so
        // no path through the block leaves one unassigned and infers a latch.
        state_n     = state;
        fetch_pc_n  = fetch_pc;
        flush_pc_n  = flush_pc;
        skid_pc_n   = skid_pc;
        skid_inst_n = skid_inst;
        pc_n        = pc_o;
        inst_n      = inst_o;
        valid_n     = valid_o;

        if (redirect_i) begin
            valid_n = 1'b0;
            inst_n  = 32'h0000_0000;
            // With no request pending (SKID), or one completing right now,
            // fetching restarts at the target directly. Otherwise the pending
            // request has to drain first, and the latest target is kept.
            if ((state == SKID) || ack) begin
                fetch_pc_n = target;
                state_n    = FETCH;
            end else begin
                flush_pc_n = target;
                state_n    = FLUSH;
            end
        end else begin
            case (state)
                FETCH: begin
                    if (ack) begin
                        fetch_pc_n = fetch_pc + 32'd4;
                        if (!valid_o || !stall_i) begin
                            pc_n    = fetch_pc;
                            inst_n  = imem_rdata_i;
                            valid_n = 1'b1;
                        end else begin
                            skid_pc_n   = fetch_pc;
                            skid_inst_n = imem_rdata_i;
                            state_n     = SKID;
                        end
                    end else if (!stall_i) begin
                        valid_n = 1'b0;
                        inst_n  = 32'h0000_0000;
                    end
                end
                SKID: begin
                    if (!stall_i) begin
                        pc_n    = skid_pc;
                        inst_n  = skid_inst;
                        valid_n = 1'b1;
                        state_n = FETCH;
                    end
                end
                FLUSH: begin
                    if (ack) begin
                        fetch_pc_n = flush_pc;
                        state_n    = FETCH;
                    end
                end
                default: state_n = FETCH;
            endcase
        end
    end

    // State register.
    always_ff @(posedge clk or posedge rst) begin
        // NOTE: sequential state uses non-blocking assignments so that every
        // register samples the pre-edge value of every other register.
        if (rst) state <= FETCH;
        else     state <= state_n;
    end

    // Fetch PC, skid buffer and IF/ID register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            fetch_pc  <= RESET_PC;
            flush_pc  <= RESET_PC;
            skid_pc   <= 32'h0000_0000;
            skid_inst <= 32'h0000_0000;
            pc_o      <= 32'h0000_0000;
            inst_o    <= 32'h0000_0000;
            valid_o   <= 1'b0;
        end else begin
            fetch_pc  <= fetch_pc_n;
            flush_pc  <= flush_pc_n;
            skid_pc   <= skid_pc_n;
            skid_inst <= skid_inst_n;
            pc_o      <= pc_n;
            inst_o    <= inst_n;
            valid_o   <= valid_n;
        end
    end

endmodule
